// File: rtl/fmap_writer_1x1_pkg.sv
// ---------------------------------------------------------------------------
// fmap_writer_1x1_pkg
//   Shared definitions for the 1x1-conv input feature-map writer.
//   - wr_state_e : writer FSM state encoding (IDLE / WRITE / DONE)
//   - cnt_width  : counter width helper, $clog2(n) but never below 1 bit
// ---------------------------------------------------------------------------
package fmap_writer_1x1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  // A single-value counter still needs one bit to exist as a signal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_writer_1x1.sv
// ---------------------------------------------------------------------------
// fmap_writer_1x1
//   Writer side of the 1x1-conv input feature-map BRAM. Accepts one pixel
//   (CHANNELS values packed side by side, channel i at
//   [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]) per handshake and serialises it into
//   byte-wide RAM writes, one channel per cycle, at linear address
//   pixel*CHANNELS + ch. Pulses frame_done after the last word of a
//   IN_HEIGHT*IN_WIDTH frame.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   s_data     in   packed pixel
//   s_valid    in   s_data valid
//   s_ready    out  pixel can be accepted this cycle
//   wr_data    out  RAM write data        (registered)
//   wr_addr    out  RAM write address     (registered)
//   wr_en      out  RAM write strobe      (registered)
//   busy       out  FSM is in WRITE
//   frame_done out  one-cycle pulse in the cycle after the frame's last word
//
// Handshake: a pixel transfers on a rising edge where s_valid & s_ready are
// both high. s_ready is decoded from state and counters only and never looks
// at s_valid; s_valid may be raised or dropped at any time and s_data is
// ignored on cycles without a transfer.
// ---------------------------------------------------------------------------
module fmap_writer_1x1
  import fmap_writer_1x1_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int IN_WIDTH   = 5,
  parameter int IN_HEIGHT  = 5,
  localparam int DEPTH     = IN_WIDTH * IN_HEIGHT * CHANNELS,
  localparam int ADDR_W    = cnt_width(DEPTH),
  localparam int CH_W      = cnt_width(CHANNELS),
  localparam int PIX_W     = DATA_WIDTH * CHANNELS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  wr_state_e state, state_nxt;

  // ch       : channel index of the word currently on wr_data
  // addr_cnt : address of the next word to be written
  // hold     : channels of the held pixel not yet written, lowest first
  logic [CH_W-1:0]       ch, ch_nxt;
  logic [ADDR_W-1:0]     addr_cnt, addr_nxt;
  logic [PIX_W-1:0]      hold, hold_nxt;

  logic                  wr_en_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic [ADDR_W-1:0]     wr_addr_nxt;
  logic                  frame_done_nxt;

  logic last_ch;
  logic frame_end;
  logic accept;

  assign last_ch = (ch == CH_LAST);
  // addr_cnt wraps to 0 right after word DEPTH-1 is issued; inside WRITE it
  // is otherwise never 0, so this flags that the last frame word is out.
  assign frame_end = (addr_cnt == '0);
  assign accept    = s_valid & s_ready;
  assign busy      = (state == ST_WRITE);

  always_comb begin
    s_ready = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE:  s_ready = 1'b1;
        ST_WRITE: s_ready = last_ch && !frame_end;
        default:  s_ready = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_ch) begin
          if (frame_end)   state_nxt = ST_DONE;
          else if (accept) state_nxt = ST_WRITE;
          else             state_nxt = ST_IDLE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values. Channel 0 is taken straight from s_data
  // on the accept edge so it lands one cycle after the handshake; the rest
  // drain from hold on following cycles.
  always_comb begin
    wr_en_nxt      = 1'b0;
    wr_data_nxt    = '0;
    wr_addr_nxt    = addr_cnt;
    frame_done_nxt = (state_nxt == ST_DONE);
    ch_nxt         = ch;
    hold_nxt       = hold;
    addr_nxt       = addr_cnt;

    if (accept) begin
      wr_en_nxt   = 1'b1;
      wr_data_nxt = s_data[DATA_WIDTH-1:0];
      hold_nxt    = s_data >> DATA_WIDTH;
      ch_nxt      = '0;
    end else if (state == ST_WRITE && !last_ch) begin
      wr_en_nxt   = 1'b1;
      wr_data_nxt = hold[DATA_WIDTH-1:0];
      hold_nxt    = hold >> DATA_WIDTH;
      ch_nxt      = ch + CH_W'(1);
    end else if (state_nxt != ST_WRITE) begin
      ch_nxt = '0;
    end

    if (wr_en_nxt) begin
      addr_nxt = (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_W'(1);
    end
    if (state == ST_DONE) begin
      addr_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_data    <= '0;
      wr_addr    <= '0;
      frame_done <= 1'b0;
      ch         <= '0;
      addr_cnt   <= '0;
      hold       <= '0;
    end else begin
      wr_en      <= wr_en_nxt;
      wr_data    <= wr_data_nxt;
      wr_addr    <= wr_addr_nxt;
      frame_done <= frame_done_nxt;
      ch         <= ch_nxt;
      addr_cnt   <= addr_nxt;
      hold       <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_fmap_writer_1x1.sv
module tb_fmap_writer_1x1;

  localparam int DW    = 8;
  localparam int CH    = 3;
  localparam int DEPTH = 75;
  localparam int AW    = 7;
  localparam int PW    = DW * CH;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  fmap_writer_1x1 #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .IN_WIDTH   (5),
    .IN_HEIGHT  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .wr_data    (wr_data),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // scoreboard: expected and observed {addr, data} words
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] log_q[$];
  int               wc_q[$];
  logic [AW-1:0]    exp_addr = '0;
  logic [DW-1:0]    mem[0:DEPTH-1];
  int               fd_cnt = 0;
  int               fd_cyc = -1;
  int               last_wr_cyc = -1;
  logic [PW-1:0]    pix_log[0:24];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin
      log_q.push_back({wr_addr, wr_data});
      wc_q.push_back(cyc);
      if (int'(wr_addr) < DEPTH) mem[wr_addr] = wr_data;
      if (wr_addr == AW'(DEPTH - 1)) last_wr_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    log_q.delete();
    wc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    exp_addr = '0;
    clear_logs();
  endtask

  // Present one pixel until it is taken; returns 1 time unit after the
  // accept edge with s_valid dropped. Expected words follow the linear map.
  task automatic send(input logic [PW-1:0] d);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send accepted", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        exp_q.push_back({exp_addr, d[c*DW +: DW]});
        exp_addr = (exp_addr == AW'(DEPTH - 1)) ? '0 : exp_addr + AW'(1);
      end
    end
    s_valid = 1'b0;
    s_data  = PW'($urandom);
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, " word count"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " word"}, 32'(log_q[i]), 32'(exp_q[i]));
    end
    clear_logs();
  endtask

  function automatic logic [PW-1:0] bram_read(input int rd_addr);
    logic [PW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = mem[rd_addr*CH + c];
    return r;
  endfunction

  initial begin
    int fd0;
    logic [PW-1:0] p;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst wr_data", 32'(wr_data), 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;

    // single pixel, latency and channel order
    s_valid = 1'b1;
    s_data  = 24'h030201;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 24'hAABBCC;
    @(negedge clk);
    check("p1 c0 wr_en", 32'(wr_en), 32'd1);
    check("p1 c0 addr", 32'(wr_addr), 32'd0);
    check("p1 c0 data", 32'(wr_data), 32'h01);
    check("p1 c0 s_ready", 32'(s_ready), 32'd0);
    check("p1 c0 busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("p1 c1 wr_en", 32'(wr_en), 32'd1);
    check("p1 c1 addr", 32'(wr_addr), 32'd1);
    check("p1 c1 data", 32'(wr_data), 32'h02);
    check("p1 c1 s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("p1 c2 wr_en", 32'(wr_en), 32'd1);
    check("p1 c2 addr", 32'(wr_addr), 32'd2);
    check("p1 c2 data", 32'(wr_data), 32'h03);
    check("p1 c2 s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    check("p1 after wr_en", 32'(wr_en), 32'd0);
    check("p1 after busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // full frame, back-to-back
    do_reset();
    fd0 = fd_cnt;
    for (int i = 0; i < 25; i++) send({8'(i), 8'(i + 100), 8'(i + 200)});
    idle(6);
    check("b2b frame_done count", 32'(fd_cnt - fd0), 32'd1);
    check("b2b frame_done timing", 32'(fd_cyc), 32'(last_wr_cyc + 1));
    if (wc_q.size() == DEPTH) check("b2b contiguous cycles", 32'(wc_q[DEPTH-1] - wc_q[0]), 32'(DEPTH - 1));
    else check("b2b write count", 32'(wc_q.size()), 32'(DEPTH));
    compare_log("b2b");

    // random gaps, next frame continues from address 0
    fd0 = fd_cnt;
    for (int i = 0; i < 25; i++) begin
      s_data = PW'($urandom);
      idle($urandom_range(0, 3));
      pix_log[i] = PW'($urandom);
      send(pix_log[i]);
    end
    idle(6);
    check("gap frame_done count", 32'(fd_cnt - fd0), 32'd1);
    compare_log("gap");
    check("bram rd_addr 12", 32'(bram_read(12)), 32'(pix_log[12]));
    check("bram rd_addr 0", 32'(bram_read(0)), 32'(pix_log[0]));

    // reset mid-frame after pixel 7 accepted
    for (int i = 0; i < 7; i++) send({8'(i + 1), 8'(i + 2), 8'(i + 3)});
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst wr_en", 32'(wr_en), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst s_ready", 32'(s_ready), 32'd0);
    check("midrst frame_done", 32'(frame_done), 32'd0);
    check("midrst words before reset", 32'(log_q.size()), 32'd19);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr = '0;
    clear_logs();
    send(24'h5A5B5C);
    idle(5);
    compare_log("midrst restart");

    // finish the frame, hold s_valid through DONE
    for (int i = 0; i < 24; i++) send({8'(i + 7), 8'(i + 77), 8'(i + 177)});
    p = 24'hC3B2A1;
    s_valid = 1'b1;
    s_data  = p;
    @(negedge clk);
    check("done-hold A s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("done-hold B s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("done-hold C s_ready", 32'(s_ready), 32'd0);
    check("done-hold C addr", 32'(wr_addr), 32'd74);
    @(negedge clk);
    check("done-hold DONE frame_done", 32'(frame_done), 32'd1);
    check("done-hold DONE s_ready", 32'(s_ready), 32'd0);
    check("done-hold DONE wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    check("done-hold IDLE s_ready", 32'(s_ready), 32'd1);
    check("done-hold IDLE wr_en", 32'(wr_en), 32'd0);
    check("done-hold IDLE frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    for (int c = 0; c < CH; c++) begin
      exp_q.push_back({exp_addr, p[c*DW +: DW]});
      exp_addr = (exp_addr == AW'(DEPTH - 1)) ? '0 : exp_addr + AW'(1);
    end
    @(negedge clk);
    check("done-hold next wr_en", 32'(wr_en), 32'd1);
    check("done-hold next addr", 32'(wr_addr), 32'd0);
    check("done-hold next data", 32'(wr_data), 32'hA1);
    idle(4);
    compare_log("done-hold");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
